inbuf_line_stage: RTL and testbench

Data-line staging buffer between the input-buffer SRAM FIFO and the encoding engine, directly downstream of the input buffer controller. It captures each line the FIFO returns after a controller read request and holds it stable on the engine data bus for exactly M compute cycles. A second, shadow line register prefetches the next line so the engine sees back-to-back lines with no bubble.

---
 rtl/inbuf_line_stage.sv | 256 +++++++++++++++++++++++++
 tb/tb_inbuf_line_stage.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inbuf_line_stage.sv
// -----------------------------------------------------------------------------
// inbuf_line_stage
//
// Data-line staging buffer between the input-buffer SRAM FIFO and the encoding
// engine. It captures each line the FIFO returns after a controller read and
// holds it stable on the engine bus for m_eff = max(m_reg, 2) compute cycles.
// A shadow register prefetches the next line so that consecutive lines reach
// the engine with no bubble.
//
// Optional feature macro: INBUF_LINE_STAGE_ERR_EN
//   defined   : sticky overflow / underflow error flags are implemented
//   undefined : both error outputs are tied to 0 (drop/ignore behaviour stays)
//
// Ports
//   clk                       clock
//   rstn                      asynchronous active-low reset
//   eng_rstn                  synchronous active-low engine reset
//   cntl_inbuf_fifo_rd_rq     controller read request to the FIFO (monitored)
//   inbuf_fifo_cntl_empty     FIFO empty flag
//   inbuf_fifo_rd_data        FIFO read data, valid 1 cycle after accepted rq
//   m_reg                     configured M
//   eng_inbuf_cntl_data_used  engine consumed the active line for one cycle
//   inbuf_eng_line_data       active line to the engine
//   inbuf_eng_line_val        active line valid
//   inbuf_shadow_val          prefetched line held
//   inbuf_line_done           one-cycle pulse: active line retired
//   inbuf_ovf_err             sticky: returned data arrived with both regs full
//   inbuf_udf_err             sticky: data_used with no valid line
//
// Occupancy FSM
//   state    | meaning
//   ST_EMPTY | no line held
//   ST_ACT   | active line held, shadow empty
//   ST_FULL  | active line and prefetched shadow line held
// -----------------------------------------------------------------------------
module inbuf_line_stage #(
  parameter int K_MAX         = 128,
  parameter int M_MAX         = 128,
  parameter int W             = 4,
  parameter int PACKET_LENGTH = 2,
  parameter int DATA_W        = K_MAX * W * PACKET_LENGTH,
  parameter int MC_W          = $clog2(M_MAX + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              eng_rstn,
  input  logic              cntl_inbuf_fifo_rd_rq,
  input  logic              inbuf_fifo_cntl_empty,
  input  logic [DATA_W-1:0] inbuf_fifo_rd_data,
  input  logic [MC_W-1:0]   m_reg,
  input  logic              eng_inbuf_cntl_data_used,
  output logic [DATA_W-1:0] inbuf_eng_line_data,
  output logic              inbuf_eng_line_val,
  output logic              inbuf_shadow_val,
  output logic              inbuf_line_done,
  output logic              inbuf_ovf_err,
  output logic              inbuf_udf_err
);

  localparam logic [MC_W-1:0] M_MIN = MC_W'(2);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ACT   = 2'd1,
    ST_FULL  = 2'd2
  } occ_t;

  occ_t state, state_nxt;

  logic              rd_pend;
  logic [DATA_W-1:0] act_data;
  logic [DATA_W-1:0] sh_data;
  logic [MC_W-1:0]   m_eff;
  logic [MC_W-1:0]   use_cnt;
  logic              line_val_q;
  logic              sh_val_q;
  logic              done_q;

  logic              rd_accept;
  logic              capture;
  logic              use_ok;
  logic              final_use;
  logic [MC_W-1:0]   m_nxt;
  logic              ld_act_fifo;
  logic              ld_act_sh;
  logic              ld_sh_fifo;

  assign rd_accept = cntl_inbuf_fifo_rd_rq & ~inbuf_fifo_cntl_empty;
  // rd_pend marks the cycle in which the FIFO drives the requested line.
  assign capture   = rd_pend;
  assign use_ok    = eng_inbuf_cntl_data_used & (state != ST_EMPTY);
  assign final_use = use_ok & (use_cnt == (m_eff - MC_W'(1)));
  assign m_nxt     = (m_reg < M_MIN) ? M_MIN : m_reg;

  // ---------------------------------------------------------------------------
  // Occupancy FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_EMPTY;
    end else if (!eng_rstn) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ld_act_fifo = 1'b0;
    ld_act_sh   = 1'b0;
    ld_sh_fifo  = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (capture) begin
          ld_act_fifo = 1'b1;
          state_nxt   = ST_ACT;
        end
      end
      ST_ACT: begin
        if (final_use) begin
          // Retiring the only line: returning data can go straight to active.
          if (capture) begin
            ld_act_fifo = 1'b1;
            state_nxt   = ST_ACT;
          end else begin
            state_nxt   = ST_EMPTY;
          end
        end else if (capture) begin
          ld_sh_fifo = 1'b1;
          state_nxt  = ST_FULL;
        end
      end
      ST_FULL: begin
        if (final_use) begin
          ld_act_sh = 1'b1;
          // The shadow slot frees in the same cycle, so a coincident capture
          // refills it instead of overflowing.
          if (capture) begin
            ld_sh_fifo = 1'b1;
            state_nxt  = ST_FULL;
          end else begin
            state_nxt  = ST_ACT;
          end
        end
        // A capture without a retire here is dropped.
      end
      default: begin
        state_nxt = ST_EMPTY;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_pend <= 1'b0;
    end else if (!eng_rstn) begin
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= rd_accept;
    end
  end

  // ---------------------------------------------------------------------------
  // Line registers and per-line M
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      act_data <= '0;
      sh_data  <= '0;
      m_eff    <= M_MIN;
    end else if (!eng_rstn) begin
      act_data <= '0;
      sh_data  <= '0;
      m_eff    <= M_MIN;
    end else begin
      if (ld_act_sh) begin
        act_data <= sh_data;
        m_eff    <= m_nxt;
      end else if (ld_act_fifo) begin
        act_data <= inbuf_fifo_rd_data;
        m_eff    <= m_nxt;
      end
      if (ld_sh_fifo) begin
        sh_data <= inbuf_fifo_rd_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Use counter and registered status outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      use_cnt    <= '0;
      line_val_q <= 1'b0;
      sh_val_q   <= 1'b0;
      done_q     <= 1'b0;
    end else if (!eng_rstn) begin
      use_cnt    <= '0;
      line_val_q <= 1'b0;
      sh_val_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (final_use) begin
        use_cnt <= '0;
      end else if (use_ok) begin
        use_cnt <= use_cnt + MC_W'(1);
      end
      line_val_q <= (state_nxt != ST_EMPTY);
      sh_val_q   <= (state_nxt == ST_FULL);
      done_q     <= final_use;
    end
  end

  assign inbuf_eng_line_data = act_data;
  assign inbuf_eng_line_val  = line_val_q;
  assign inbuf_shadow_val    = sh_val_q;
  assign inbuf_line_done     = done_q;

  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
`ifdef INBUF_LINE_STAGE_ERR_EN
  logic ovf_evt;
  logic udf_evt;
  logic ovf_q;
  logic udf_q;

  assign ovf_evt = capture & (state == ST_FULL) & ~final_use;
  assign udf_evt = eng_inbuf_cntl_data_used & (state == ST_EMPTY);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (!eng_rstn) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (ovf_evt) ovf_q <= 1'b1;
      if (udf_evt) udf_q <= 1'b1;
    end
  end

  assign inbuf_ovf_err = ovf_q;
  assign inbuf_udf_err = udf_q;
`else
  assign inbuf_ovf_err = 1'b0;
  assign inbuf_udf_err = 1'b0;
`endif

endmodule

// File: tb/tb_inbuf_line_stage.sv
// -----------------------------------------------------------------------------
// tb_inbuf_line_stage
//
// Directed bench for inbuf_line_stage. Inputs are driven 1 ns after the rising
// edge and outputs are sampled at the same point, i.e. the values seen reflect
// the registers updated by the edge just passed.
// -----------------------------------------------------------------------------
module tb_inbuf_line_stage;

  localparam int K_MAX         = 128;
  localparam int M_MAX         = 128;
  localparam int W             = 4;
  localparam int PACKET_LENGTH = 2;
  localparam int DATA_W        = K_MAX * W * PACKET_LENGTH;
  localparam int MC_W          = $clog2(M_MAX + 1);

`ifdef INBUF_LINE_STAGE_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic              clk;
  logic              rstn;
  logic              eng_rstn;
  logic              rd_rq;
  logic              fifo_empty;
  logic [DATA_W-1:0] rd_data;
  logic [MC_W-1:0]   m_reg;
  logic              data_used;
  logic [DATA_W-1:0] line_data;
  logic              line_val;
  logic              shadow_val;
  logic              line_done;
  logic              ovf_err;
  logic              udf_err;

  int n_tests;
  int n_fail;

  inbuf_line_stage #(
    .K_MAX(K_MAX), .M_MAX(M_MAX), .W(W), .PACKET_LENGTH(PACKET_LENGTH),
    .DATA_W(DATA_W), .MC_W(MC_W)
  ) dut (
    .clk                      (clk),
    .rstn                     (rstn),
    .eng_rstn                 (eng_rstn),
    .cntl_inbuf_fifo_rd_rq    (rd_rq),
    .inbuf_fifo_cntl_empty    (fifo_empty),
    .inbuf_fifo_rd_data       (rd_data),
    .m_reg                    (m_reg),
    .eng_inbuf_cntl_data_used (data_used),
    .inbuf_eng_line_data      (line_data),
    .inbuf_eng_line_val       (line_val),
    .inbuf_shadow_val         (shadow_val),
    .inbuf_line_done          (line_done),
    .inbuf_ovf_err            (ovf_err),
    .inbuf_udf_err            (udf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mk_line(input int n);
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W / 32; i++) begin
      v[i*32 +: 32] = 32'hA500_0000 + 32'(n) * 32'h0001_0000 + 32'(i);
    end
    return v;
  endfunction

  logic [DATA_W-1:0] junk;
  logic [DATA_W-1:0] zero_line;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got,
                     input logic [DATA_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (low 64 bits)", tag, got[63:0], exp[63:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepted read; returns in the cycle the line is visible if it lands in active.
  task automatic do_read(input logic [DATA_W-1:0] d);
    rd_rq = 1'b1;
    tick();
    rd_rq   = 1'b0;
    rd_data = d;
    tick();
    rd_data = junk;
  endtask

  // Holds data_used high until line_done is seen; n = number of uses, 0 on timeout.
  task automatic count_uses(input int max_uses, output int n);
    n = 0;
    data_used = 1'b1;
    for (int i = 1; i <= max_uses; i++) begin
      tick();
      if (line_done) begin
        n = i;
        break;
      end
    end
    data_used = 1'b0;
  endtask

  task automatic eng_reset();
    eng_rstn = 1'b0;
    tick();
    eng_rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int n_uses;
  int n_done;
  logic gap;
  logic [DATA_W-1:0] d3, d4;

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    junk       = mk_line(99);
    zero_line  = '0;
    rstn       = 1'b0;
    eng_rstn   = 1'b1;
    rd_rq      = 1'b0;
    fifo_empty = 1'b0;
    rd_data    = junk;
    m_reg      = MC_W'(3);
    data_used  = 1'b0;

    repeat (3) tick();
    chk("rst_val",  line_val,   1'b0);
    chk("rst_sh",   shadow_val, 1'b0);
    chk("rst_done", line_done,  1'b0);
    chk("rst_data", line_data,  zero_line);
    rstn = 1'b1;
    tick();

    // Single line, m=3, fill latency
    rd_rq = 1'b1;
    tick();
    chk("fill_t1_val", line_val, 1'b0);
    rd_rq   = 1'b0;
    rd_data = mk_line(1);
    tick();
    rd_data = junk;
    chk("fill_t2_val",  line_val,  1'b1);
    chk("fill_t2_data", line_data, mk_line(1));
    count_uses(8, n_uses);
    chk("m3_uses", n_uses, 3);
    chk("m3_val_after", line_val, 1'b0);
    tick();
    chk("m3_done_single", line_done, 1'b0);

    // Prefetch back-to-back, m=4
    m_reg = MC_W'(4);
    do_read(mk_line(2));
    do_read(mk_line(3));
    chk("pf_shadow", shadow_val, 1'b1);
    n_done = 0;
    gap    = 1'b0;
    d3     = '0;
    d4     = '0;
    data_used = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (line_done) n_done++;
      if (i < 8 && !line_val) gap = 1'b1;
      if (i == 3) d3 = line_data;
      if (i == 4) d4 = line_data;
    end
    data_used = 1'b0;
    chk("pf_done_cnt", n_done, 2);
    chk("pf_gap", gap, 1'b0);
    chk("pf_data_a", d3, mk_line(2));
    chk("pf_data_b", d4, mk_line(3));
    chk("pf_val_end", line_val, 1'b0);

    // Simultaneous retire and capture, m=2
    m_reg = MC_W'(2);
    do_read(mk_line(4));
    do_read(mk_line(5));
    rd_rq     = 1'b1;
    data_used = 1'b1;
    tick();
    rd_rq   = 1'b0;
    rd_data = mk_line(6);
    tick();
    rd_data   = junk;
    data_used = 1'b0;
    chk("sim_done", line_done, 1'b1);
    chk("sim_data", line_data, mk_line(5));
    chk("sim_sh",   shadow_val, 1'b1);
    chk("sim_ovf",  ovf_err, 1'b0);
    count_uses(4, n_uses);
    chk("sim_b_uses", n_uses, 2);
    chk("sim_c_data", line_data, mk_line(6));
    chk("sim_c_sh",   shadow_val, 1'b0);
    count_uses(4, n_uses);
    chk("sim_c_uses", n_uses, 2);
    chk("sim_val_end", line_val, 1'b0);

    // Overflow then underflow
    eng_reset();
    do_read(mk_line(7));
    do_read(mk_line(8));
    do_read(mk_line(9));
    chk("ovf_flag", ovf_err, ERR_EN);
    chk("ovf_act",  line_data, mk_line(7));
    chk("ovf_sh",   shadow_val, 1'b1);
    count_uses(4, n_uses);
    chk("ovf_second", line_data, mk_line(8));
    chk("ovf_sh_after", shadow_val, 1'b0);
    eng_reset();
    chk("erst_ovf",  ovf_err, 1'b0);
    chk("erst_val",  line_val, 1'b0);
    chk("erst_data", line_data, zero_line);
    data_used = 1'b1;
    tick();
    data_used = 1'b0;
    chk("udf_flag", udf_err, ERR_EN);
    chk("udf_done", line_done, 1'b0);
    tick();
    chk("udf_sticky", udf_err, ERR_EN);
    eng_reset();
    chk("erst_udf", udf_err, 1'b0);

    // m_reg = 0 and 1 both hold for 2 uses
    for (int mv = 0; mv < 2; mv++) begin
      m_reg = MC_W'(mv);
      do_read(mk_line(10 + mv));
      count_uses(6, n_uses);
      chk($sformatf("mmin_uses_m%0d", mv), n_uses, 2);
    end

    // m_reg change mid-line: 3 for current line, 5 for next
    m_reg = MC_W'(3);
    do_read(mk_line(12));
    do_read(mk_line(13));
    data_used = 1'b1;
    tick();
    m_reg = MC_W'(5);
    count_uses(10, n_uses);
    chk("mchg_rest_a", n_uses, 2);
    chk("mchg_data_b", line_data, mk_line(13));
    count_uses(10, n_uses);
    chk("mchg_uses_b", n_uses, 5);

    // eng_rstn the cycle after an accepted read discards the returning line
    m_reg = MC_W'(2);
    rd_rq = 1'b1;
    tick();
    rd_rq    = 1'b0;
    rd_data  = mk_line(14);
    eng_rstn = 1'b0;
    tick();
    eng_rstn = 1'b1;
    rd_data  = junk;
    chk("disc_val_t1", line_val, 1'b0);
    tick();
    chk("disc_val_t2", line_val, 1'b0);
    chk("disc_data",   line_data, zero_line);
    do_read(mk_line(15));
    count_uses(6, n_uses);
    chk("disc_cnt_clear", n_uses, 2);
    chk("disc_ovf", ovf_err, 1'b0);
    chk("disc_udf", udf_err, 1'b0);

    // Read request while FIFO empty is ignored
    fifo_empty = 1'b1;
    rd_rq      = 1'b1;
    tick();
    rd_rq      = 1'b0;
    fifo_empty = 1'b0;
    rd_data    = mk_line(16);
    tick();
    rd_data = junk;
    tick();
    chk("empty_rq_val", line_val, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
